mem_access_unit: RTL

- Load/store unit between the execute stage and the data port of the byte-addressed dual-port RAM (address port 2, read data out2, write_mode/write_addr/write_data).
- Accepts one memory request at a time over a valid/ready handshake.
- Drives the RAM's registered read and write interface, then returns sign- or zero-extended load data, or a store acknowledgement, over a valid/ready response handshake.
- Flags misaligned and illegal requests without touching memory.

---
 rtl/mem_access_unit_pkg.sv | 52 +++++
 rtl/mem_access_unit_load_extend.sv | 29 ++
 rtl/mem_access_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the load/store unit: RV32I funct3 codes, RAM write modes,
// FSM state encodings and request decode helpers.
package mem_access_unit_pkg;

  localparam int XLEN_WIDTH = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WM_NONE = 2'b00;
  localparam logic [1:0] WM_BYTE = 2'b01;
  localparam logic [1:0] WM_HALF = 2'b10;
  localparam logic [1:0] WM_WORD = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD1  = 3'd1;
  localparam logic [2:0] ST_RD2  = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  function automatic logic op_illegal(input logic we, input logic [2:0] op);
    logic bad;
    if (we) bad = !(op == F3_B || op == F3_H || op == F3_W);
    else    bad = !(op == F3_B || op == F3_H || op == F3_W || op == F3_BU || op == F3_HU);
    return bad;
  endfunction

  function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] lo);
    logic mis;
    case (op)
      F3_H, F3_HU: mis = lo[0];
      F3_W:        mis = (lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [1:0] store_mode(input logic [2:0] op);
    logic [1:0] m;
    case (op)
      F3_B:    m = WM_BYTE;
      F3_H:    m = WM_HALF;
      F3_W:    m = WM_WORD;
      default: m = WM_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Selects the byte/half/word of a little-endian RAM word for a load and
// applies sign or zero extension according to funct3.
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [XLEN_WIDTH-1:0] word,
  input  logic [1:0]            addr_lo,
  input  logic [2:0]            op,
  output logic [XLEN_WIDTH-1:0] value
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[{addr_lo, 3'b000} +: 8];
    sel_half = addr_lo[1] ? word[31:16] : word[15:0];
    value    = '0;
    case (op)
      F3_B:    value = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   value = {24'h0, sel_byte};
      F3_H:    value = {{16{sel_half[15]}}, sel_half};
      F3_HU:   value = {16'h0, sel_half};
      F3_W:    value = word;
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one request at a time between execute and the RAM data port,
// with registered RAM-side outputs and a held response until consumed.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_op,
  input  logic [XLEN_WIDTH-1:0] req_addr,
  input  logic [XLEN_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [XLEN_WIDTH-1:0] resp_data,
  output logic [4:0]            resp_rd,
  output logic                  resp_err,
  output logic [XLEN_WIDTH-1:0] ram_addr,
  input  logic [XLEN_WIDTH-1:0] ram_rdata,
  output logic [1:0]            ram_write_mode,
  output logic [XLEN_WIDTH-1:0] ram_write_addr,
  output logic [XLEN_WIDTH-1:0] ram_write_data
);

  logic [2:0]            state;
  logic [2:0]            op_q;
  logic [1:0]            lo_q;
  logic                  req_err;
  logic [XLEN_WIDTH-1:0] ext_data;

  assign req_ready = (state == ST_IDLE);
  assign req_err   = op_illegal(req_we, req_op) || op_misaligned(req_op, req_addr[1:0]);

  load_extend u_load_extend (
    .word    (ram_rdata),
    .addr_lo (lo_q),
    .op      (op_q),
    .value   (ext_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ST_IDLE;
      op_q           <= '0;
      lo_q           <= '0;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      resp_rd        <= '0;
      resp_err       <= 1'b0;
      ram_addr       <= '0;
      ram_write_mode <= WM_NONE;
      ram_write_addr <= '0;
      ram_write_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            lo_q      <= req_addr[1:0];
            resp_rd   <= req_rd;
            resp_data <= '0;
            resp_err  <= 1'b0;
            if (req_err) begin
              // Errors skip the RAM entirely and respond straight away.
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end else if (req_we) begin
              ram_write_mode <= store_mode(req_op);
              ram_write_addr <= req_addr;
              ram_write_data <= req_wdata;
              state          <= ST_WR;
            end else begin
              ram_addr <= {req_addr[XLEN_WIDTH-1:2], 2'b00};
              state    <= ST_RD1;
            end
          end
        end
        ST_RD1: begin
          state <= ST_RD2;
        end
        ST_RD2: begin
          resp_data  <= ext_data;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_WR: begin
          ram_write_mode <= WM_NONE;
          resp_valid     <= 1'b1;
          state          <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid     <= 1'b0;
          ram_write_mode <= WM_NONE;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
